// File: rtl/cosine_sim_feeder.sv
// Front-end sequencer for the cosine similarity engine: gathers vectors A and B
// from an element stream, kicks the engine, and returns its result (or a timeout).
module cosine_sim_feeder #(
  parameter int W       = 5,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_data,
  output logic [W-1:0][31:0]   vec_a,
  output logic [W-1:0][31:0]   vec_b,
  output logic                 start,
  input  logic [31:0]          sim_in,
  input  logic                 sim_valid,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [31:0]          res_data,
  output logic                 res_err,
  output logic                 busy
);

  localparam int IDX_W = (W > 1) ? $clog2(W) : 1;
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {LOAD_A, LOAD_B, KICK, WAIT, OUT} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx;
  logic [TMR_W-1:0]   tmr;
  logic               accept;
  logic               last_beat;
  logic               tmr_done;

  assign accept    = in_valid && in_ready;
  assign last_beat = (idx == IDX_W'(W - 1));
  assign tmr_done  = (tmr == TMR_W'(TIMEOUT - 1));

  // Handshake outputs decode from state only, so no input reaches them combinationally
  always_comb begin
    in_ready  = 1'b0;
    start     = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;
    state_d   = state_q;
    case (state_q)
      LOAD_A: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (accept && last_beat) state_d = LOAD_B;
      end
      LOAD_B: begin
        in_ready = 1'b1;
        if (accept && last_beat) state_d = KICK;
      end
      KICK: begin
        start   = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (sim_valid || tmr_done) state_d = OUT;
      end
      OUT: begin
        res_valid = 1'b1;
        if (res_ready) state_d = LOAD_A;
      end
      default: state_d = LOAD_A;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= LOAD_A;
      idx      <= '0;
      tmr      <= '0;
      vec_a    <= '0;
      vec_b    <= '0;
      res_data <= '0;
      res_err  <= 1'b0;
    end else begin
      state_q <= state_d;

      if (accept) begin
        idx <= last_beat ? '0 : idx + IDX_W'(1);
        for (int i = 0; i < W; i++) begin
          if (idx == IDX_W'(i)) begin
            if (state_q == LOAD_A) vec_a[i] <= in_data;
            else                   vec_b[i] <= in_data;
          end
        end
      end

      if (state_q == KICK)      tmr <= '0;
      else if (state_q == WAIT) tmr <= tmr + TMR_W'(1);

      // An engine response in the expiry cycle takes priority over the timeout
      if (state_q == WAIT) begin
        if (sim_valid) begin
          res_data <= sim_in;
          res_err  <= 1'b0;
        end else if (tmr_done) begin
          res_data <= '0;
          res_err  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cosine_sim_feeder.sv
// Directed bench for cosine_sim_feeder: table of load/response scenarios plus
// hand sequences for stray engine pulses and a mid-load reset.
module tb_cosine_sim_feeder;

  localparam int W       = 5;
  localparam int TIMEOUT = 64;
  localparam int NO_RESP = 999;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        in_data;
  logic [W-1:0][31:0] vec_a;
  logic [W-1:0][31:0] vec_b;
  logic               start;
  logic [31:0]        sim_in;
  logic               sim_valid;
  logic               res_valid;
  logic               res_ready;
  logic [31:0]        res_data;
  logic               res_err;
  logic               busy;

  int checks = 0;
  int errors = 0;

  cosine_sim_feeder #(.W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .vec_a(vec_a), .vec_b(vec_b), .start(start),
    .sim_in(sim_in), .sim_valid(sim_valid),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_err(res_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] a_base;
    int          a_step;
    logic [31:0] b_base;
    int          b_step;
    bit          gaps;
    int          resp_delay;   // cycles after the start cycle that sim_valid is driven
    logic [31:0] sim_val;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;      // cycles from start to first res_valid
    int          hold;         // cycles res_ready stays low during OUT
  } scen_t;

  scen_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] elem(input logic [31:0] base, input int step, input int i);
    return base + 32'(i * step);
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, ".in_ready"},  32'(in_ready),  32'd1);
    check({tag, ".start"},     32'(start),     32'd0);
    check({tag, ".res_valid"}, 32'(res_valid), 32'd0);
    check({tag, ".res_data"},  res_data,       32'd0);
    check({tag, ".res_err"},   32'(res_err),   32'd0);
    check({tag, ".busy"},      32'(busy),      32'd0);
    for (int i = 0; i < W; i++) begin
      check($sformatf("%s.vec_a[%0d]", tag, i), vec_a[i], 32'd0);
      check($sformatf("%s.vec_b[%0d]", tag, i), vec_b[i], 32'd0);
    end
  endtask

  task automatic run_scenario(input scen_t s);
    int start_cnt;
    int start_cyc;
    int lat;
    // load A then B, optionally with an idle cycle after every beat but the last
    for (int k = 0; k < 2 * W; k++) begin
      in_valid = 1'b1;
      in_data  = (k < W) ? elem(s.a_base, s.a_step, k) : elem(s.b_base, s.b_step, k - W);
      check($sformatf("%s.in_ready_beat%0d", s.name, k), 32'(in_ready), 32'd1);
      check($sformatf("%s.busy_beat%0d", s.name, k), 32'(busy), (k < W) ? 32'd0 : 32'd1);
      tick();
      in_valid = 1'b0;
      if (s.gaps && k != 2 * W - 1) tick();
    end
    // now in the cycle after the last accepted beat
    sim_in    = s.sim_val;
    start_cnt = 0;
    start_cyc = -1;
    lat       = -1;
    for (int c = 0; c < 100 && lat < 0; c++) begin
      if (start) begin
        start_cnt++;
        if (start_cyc < 0) start_cyc = c;
      end
      if (c > 0) check($sformatf("%s.in_ready_wait%0d", s.name, c), 32'(in_ready), 32'd0);
      if (res_valid) lat = c;
      else begin
        sim_valid = (c == s.resp_delay);
        tick();
        sim_valid = 1'b0;
      end
    end
    check({s.name, ".start_count"}, 32'(start_cnt), 32'd1);
    check({s.name, ".start_cycle"}, 32'(start_cyc), 32'd0);
    check({s.name, ".res_latency"}, 32'(lat), 32'(s.exp_lat));
    check({s.name, ".res_data"}, res_data, s.exp_data);
    check({s.name, ".res_err"}, 32'(res_err), 32'(s.exp_err));
    for (int i = 0; i < W; i++) begin
      check($sformatf("%s.vec_a[%0d]", s.name, i), vec_a[i], elem(s.a_base, s.a_step, i));
      check($sformatf("%s.vec_b[%0d]", s.name, i), vec_b[i], elem(s.b_base, s.b_step, i));
    end
    if (lat < 0) return;
    // backpressure on the result port
    res_ready = 1'b0;
    for (int h = 0; h < s.hold; h++) begin
      tick();
      check($sformatf("%s.hold_valid%0d", s.name, h), 32'(res_valid), 32'd1);
      check($sformatf("%s.hold_data%0d", s.name, h), res_data, s.exp_data);
      check($sformatf("%s.hold_in_ready%0d", s.name, h), 32'(in_ready), 32'd0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({s.name, ".post_in_ready"}, 32'(in_ready), 32'd1);
    check({s.name, ".post_res_valid"}, 32'(res_valid), 32'd0);
    check({s.name, ".post_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    //          name       a_base  a_step b_base   b_step gaps delay    sim_val        exp_data       err  lat  hold
    tbl[0] = '{"basic",   32'd1,   1,  32'd5,     -1,   0,   6,       32'h0000_2A00, 32'h0000_2A00, 1'b0, 7,   0};
    tbl[1] = '{"timeout", 32'd100, 3,  32'd200,    7,   0,   NO_RESP, 32'h5555_5555, 32'h0000_0000, 1'b1, 65,  2};
    tbl[2] = '{"race",    32'hF0,  16, 32'h7FFF_FFFE, 1, 0,  64,      32'h0000_1234, 32'h0000_1234, 1'b0, 65,  1};
    tbl[3] = '{"gaps",    32'h10,  1,  32'h20,     2,   1,   10,      32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 11,  20};
    tbl[4] = '{"postrst", 32'hA0,  5,  32'hB0,    -5,   0,   1,       32'h0BAD_F00D, 32'h0BAD_F00D, 1'b0, 2,   0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    sim_in    = '0;
    sim_valid = 1'b0;
    res_ready = 1'b0;
    #3;
    check_reset_values("reset");
    tick();
    tick();
    rst = 1'b0;
    tick();

    for (int t = 0; t < 4; t++) run_scenario(tbl[t]);

    // stray engine pulses while idle in LOAD_A are ignored
    sim_in = 32'hCAFE_0001;
    for (int c = 0; c < 3; c++) begin
      sim_valid = 1'b1;
      tick();
      check($sformatf("stray.in_ready%0d", c), 32'(in_ready), 32'd1);
      check($sformatf("stray.res_valid%0d", c), 32'(res_valid), 32'd0);
      check($sformatf("stray.busy%0d", c), 32'(busy), 32'd0);
      check($sformatf("stray.res_data%0d", c), res_data, 32'hDEAD_BEEF);
    end
    sim_valid = 1'b0;

    // reset asserted mid-way through loading B
    for (int k = 0; k < W + 3; k++) begin
      in_valid = 1'b1;
      in_data  = 32'h7700 + 32'(k);
      tick();
    end
    in_valid = 1'b0;
    check("midrst.busy_before", 32'(busy), 32'd1);
    check("midrst.vec_b1_before", vec_b[1], 32'h7700 + 32'(W + 1));
    rst = 1'b1;
    #1;
    check_reset_values("midrst");
    tick();
    rst = 1'b0;
    tick();
    run_scenario(tbl[4]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
